// File: rtl/ifetch_ctrl_pkg.sv
// ifetch_ctrl_pkg: shared types and widths for the instruction fetch controller.
// Holds the FSM state enum, address/instruction widths and the default halt word.
package ifetch_ctrl_pkg;

   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 32;
   localparam int CNT_W   = 16;

   localparam logic [INSTR_W-1:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HALT
   } state_t;

endpackage

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetch FSM feeding one registered instruction entry to decode.
// Ports: clk, rst (sync, active-high), start, stall, redirect_valid/addr,
//   imem_addr/imem_data (combinational memory), instr/instr_pc/instr_valid,
//   instr_ready, halted, instr_count (saturating issue counter).
// Build option: IFETCH_WRAP_HALT_EN halts after issuing pc 8'hFF
//   instead of wrapping to 8'h00.
module ifetch_ctrl
   import ifetch_ctrl_pkg::*;
#(
   parameter logic [ADDR_W-1:0]  RESET_PC   = 8'h00,
   parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic               halted,
   output logic [CNT_W-1:0]   instr_count
);

   state_t             state, state_n;
   logic [ADDR_W-1:0]  pc, pc_n;
   logic [INSTR_W-1:0] instr_n;
   logic [ADDR_W-1:0]  ipc_n;
   logic               valid_n;
   logic [CNT_W-1:0]   cnt_n;
   logic               issue;

   assign imem_addr = pc;
   assign halted    = (state == HALT);

   // The output slot is free when empty or being drained this cycle.
   assign issue = (state == FETCH) && !redirect_valid && !stall &&
                  (!instr_valid || instr_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         instr_count <= '0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         instr       <= instr_n;
         instr_pc    <= ipc_n;
         instr_valid <= valid_n;
         instr_count <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      instr_n = instr;
      ipc_n   = instr_pc;
      valid_n = instr_valid;
      cnt_n   = instr_count;
      unique case (state)
         IDLE, HALT: begin
            // A leftover entry can still drain while stopped.
            if (instr_valid && instr_ready)
               valid_n = 1'b0;
            if (start) begin
               pc_n    = RESET_PC;
               cnt_n   = '0;
               state_n = FETCH;
            end
         end
         FETCH: begin
            if (redirect_valid) begin
               pc_n    = redirect_addr;
               valid_n = 1'b0;
            end else if (issue) begin
               if (imem_data == HALT_INSTR) begin
                  valid_n = 1'b0;
                  state_n = HALT;
               end else begin
                  instr_n = imem_data;
                  ipc_n   = pc;
                  valid_n = 1'b1;
                  if (instr_count != '1)
                     cnt_n = instr_count + 1'b1;
`ifdef IFETCH_WRAP_HALT_EN
                  if (pc == '1)
                     state_n = HALT;
                  else
                     pc_n = pc + 1'b1;
`else
                  pc_n = pc + 1'b1;
`endif
               end
            end else if (instr_valid && instr_ready) begin
               valid_n = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed and randomized checks of ifetch_ctrl against
// a behavioural model. Honors IFETCH_WRAP_HALT_EN for the pc 8'hFF case.
module tb_ifetch_ctrl;

   localparam logic [31:0] HW = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst, start, stall, redirect_valid, instr_ready;
   logic [7:0]  redirect_addr, imem_addr, instr_pc;
   logic [31:0] imem_data, instr;
   logic        instr_valid, halted;
   logic [15:0] instr_count;

   logic [31:0] mem [256];

   int checks = 0;
   int errors = 0;

   // Model: mode 0 = idle, 1 = fetching, 2 = halted
   int          m_mode;
   logic [7:0]  m_pc, m_ipc;
   logic [31:0] m_instr;
   logic        m_valid;
   logic [15:0] m_cnt;

   ifetch_ctrl dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .stall(stall),
      .redirect_valid(redirect_valid),
      .redirect_addr(redirect_addr),
      .imem_addr(imem_addr),
      .imem_data(imem_data),
      .instr(instr),
      .instr_pc(instr_pc),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .halted(halted),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic [31:0] w;
      if (rst) begin
         m_mode = 0; m_pc = 8'h00; m_ipc = 8'h00;
         m_instr = 32'h0; m_valid = 1'b0; m_cnt = 16'h0;
      end else if (m_mode != 1) begin
         if (m_valid && instr_ready) m_valid = 1'b0;
         if (start) begin
            m_mode = 1; m_pc = 8'h00; m_cnt = 16'h0;
         end
      end else if (redirect_valid) begin
         m_pc = redirect_addr;
         m_valid = 1'b0;
      end else if (!stall && (!m_valid || instr_ready)) begin
         w = mem[m_pc];
         if (w == HW) begin
            m_valid = 1'b0;
            m_mode = 2;
         end else begin
            m_instr = w; m_ipc = m_pc; m_valid = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`ifdef IFETCH_WRAP_HALT_EN
            if (m_pc == 8'hFF) m_mode = 2;
            else m_pc = m_pc + 8'd1;
`else
            m_pc = 8'((int'(m_pc) + 1) % 256);
`endif
         end
      end else if (m_valid && instr_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic step(input logic st, input logic rs, input logic stl,
                       input logic rv, input logic [7:0] ra,
                       input logic rdy);
      start = st; rst = rs; stall = stl;
      redirect_valid = rv; redirect_addr = ra; instr_ready = rdy;
      model_edge();
      @(posedge clk);
      #1;
      chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("halted", 32'(halted), 32'(m_mode == 2));
      chk("instr_count", 32'(instr_count), 32'(m_cnt));
      chk("instr", instr, m_instr);
      chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
   endtask

   initial begin
      for (int i = 0; i < 256; i++)
         mem[i] = $urandom & 32'h7FFF_FFFF;
      mem[0] = 32'h0C01_0018;
      mem[1] = 32'h0401_00FA;
      mem[2] = 32'h1402_001F;
      mem[3] = HW;

      // reset
      step(0, 1, 0, 0, 8'h00, 1);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_count", 32'(instr_count), 32'h0);
      chk("rst_pc", 32'(imem_addr), 32'h0);

      // start then three back-to-back entries, then halt
      step(1, 0, 0, 0, 8'h00, 1);
      chk("start_lat", 32'(instr_valid), 32'h0);
      step(0, 0, 0, 0, 8'h00, 1);
      chk("e0_pc", 32'(instr_pc), 32'h0);
      chk("e0_instr", instr, 32'h0C01_0018);
      step(0, 0, 0, 0, 8'h00, 1);
      chk("e1_pc", 32'(instr_pc), 32'h1);
      step(0, 0, 0, 0, 8'h00, 1);
      chk("e2_pc", 32'(instr_pc), 32'h2);
      chk("e2_instr", instr, 32'h1402_001F);
      step(0, 0, 0, 0, 8'h00, 1);
      chk("halt_halted", 32'(halted), 32'h1);
      chk("halt_count", 32'(instr_count), 32'h3);
      chk("halt_valid", 32'(instr_valid), 32'h0);
      step(0, 0, 0, 1, 8'h40, 1);
      chk("halt_ignores_redir", 32'(imem_addr), 32'h3);

      // backpressure holds the first entry
      step(1, 0, 0, 0, 8'h00, 1);
      step(0, 0, 0, 0, 8'h00, 1);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 0, 8'h00, 0);
         chk("bp_instr", instr, 32'h0C01_0018);
         chk("bp_pc", 32'(instr_pc), 32'h0);
         chk("bp_fetch_pc", 32'(imem_addr), 32'h1);
      end
      step(0, 0, 0, 0, 8'h00, 1);
      chk("bp_next_pc", 32'(instr_pc), 32'h1);
      chk("bp_next_instr", instr, 32'h0401_00FA);
      chk("bp_count", 32'(instr_count), 32'h2);

      // redirect beats stall
      step(0, 0, 1, 1, 8'h0A, 1);
      chk("redir_flush", 32'(instr_valid), 32'h0);
      chk("redir_pc", 32'(imem_addr), 32'h0A);
      step(0, 0, 0, 0, 8'h00, 1);
      chk("redir_entry", 32'(instr_pc), 32'h0A);

      // pc 8'hFF boundary
      step(0, 0, 0, 1, 8'hFF, 1);
      step(0, 0, 0, 0, 8'h00, 1);
      chk("ff_entry", 32'(instr_pc), 32'hFF);
`ifdef IFETCH_WRAP_HALT_EN
      chk("ff_halted", 32'(halted), 32'h1);
      chk("ff_valid", 32'(instr_valid), 32'h1);
`else
      step(0, 0, 0, 0, 8'h00, 1);
      chk("wrap_entry", 32'(instr_pc), 32'h00);
      chk("wrap_halted", 32'(halted), 32'h0);
`endif

      // reset mid-stream, then refetch
      step(1, 0, 0, 0, 8'h00, 1);
      step(0, 0, 0, 0, 8'h00, 1);
      chk("mid_valid", 32'(instr_valid), 32'h1);
      step(0, 1, 0, 0, 8'h00, 0);
      chk("mid_rst_valid", 32'(instr_valid), 32'h0);
      chk("mid_rst_instr", instr, 32'h0);
      chk("mid_rst_ipc", 32'(instr_pc), 32'h0);
      chk("mid_rst_count", 32'(instr_count), 32'h0);
      step(0, 0, 0, 1, 8'h33, 1);
      chk("idle_ignores_redir", 32'(imem_addr), 32'h0);
      step(1, 0, 0, 0, 8'h00, 1);
      step(0, 0, 0, 0, 8'h00, 1);
      chk("refetch_pc", 32'(instr_pc), 32'h0);
      chk("refetch_instr", instr, 32'h0C01_0018);

      // randomized traffic with sparse halt words
      for (int i = 0; i < 256; i++)
         mem[i] = ($urandom_range(0, 15) == 0) ? HW : $urandom;
      for (int c = 0; c < 600; c++)
         step(($urandom_range(0, 9) == 0), ($urandom_range(0, 79) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
              8'($urandom), ($urandom_range(0, 2) != 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00: fetch start address after reset/start.
REQ-002 SHALL have parameter HALT_INSTR, default 32'hFFFF_FFFF: instruction word that stops fetch.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: begin fetching at RESET_PC from IDLE or HALT.
REQ-006 SHALL have port stall, input, 1: freeze PC and output register.
REQ-007 SHALL have port redirect_valid, input, 1: branch/jump taken.
REQ-008 SHALL have port redirect_addr, input, 8: target word address.
REQ-009 SHALL have port imem_addr, output, 8: word address to instruction memory (combinational read).
REQ-010 SHALL have port imem_data, input, 32: instruction word at imem_addr, same cycle.
REQ-011 SHALL have port instr, output, 32: registered instruction to decode.
REQ-012 SHALL have port instr_pc, output, 8: address of instr.
REQ-013 SHALL have port instr_valid, output, 1: instr/instr_pc hold a valid entry.
REQ-014 SHALL have port instr_ready, input, 1: decode accepts entry when instr_valid high.
REQ-015 SHALL have port halted, output, 1: FSM in HALT.
REQ-016 SHALL have port instr_count, output, 16: issued instructions since start, saturating at 16'hFFFF.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, HALT.
REQ-018 SHALL drive imem_addr = pc at all times.
REQ-019 IDLE: start=1 -> pc<=RESET_PC, instr_count<=0, go FETCH; else hold.
REQ-020 FETCH issue condition: !stall and (!instr_valid or instr_ready) and !redirect_valid.
REQ-021 On issue with imem_data != HALT_INSTR: instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1 (mod 256), instr_count<=sat(instr_count+1).
REQ-022 On issue with imem_data == HALT_INSTR: no entry captured, instr_valid<=0, pc held, go HALT.
REQ-023 No issue and instr_valid and instr_ready: instr_valid<=0.
REQ-024 redirect_valid in FETCH SHALL take priority over stall and issue: pc<=redirect_addr, instr_valid<=0 (flush), no count change.
REQ-025 HALT: redirect_valid ignored; start=1 behaves as REQ-019; halted=1.
REQ-026 Latency: start at edge N -> FETCH at N+1 -> instr_valid=1 with instr=IMEM[RESET_PC] after edge N+2.
REQ-027 Throughput SHALL be one instruction per cycle while instr_ready=1 and stall=0.
REQ-028 start in FETCH SHALL be ignored.

Reset
REQ-029 rst=1 at a clock edge SHALL force state IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, instr_count=0, halted=0, overriding all other inputs including mid-fetch.

Configuration
REQ-030 Without IFETCH_WRAP_HALT_EN, pc SHALL wrap 8'hFF -> 8'h00 and fetch continues.
REQ-031 With IFETCH_WRAP_HALT_EN defined, issuing at pc=8'hFF SHALL capture that entry normally and then go HALT instead of wrapping.

Structure
REQ-032 Shared package SHALL hold FSM state typedef (IDLE/FETCH/HALT), address width 8, instruction width 32, default HALT_INSTR.
REQ-033 Single module, no sub-module; instruction memory stays external.

Verification
REQ-034 Reset, start, memory IMEM[0..2]=32'h0C010018, 32'h0401_00FA, 32'h1402_001F, IMEM[3]=HALT_INSTR, ready=1 -> three entries pc 0,1,2 back-to-back, then halted=1, instr_count=3.
REQ-035 instr_ready=0 for 3 cycles after first entry -> instr=32'h0C010018 and instr_pc=0 held, pc held at 1, no loss or duplicate.
REQ-036 redirect_valid=1 addr=8'h0A together with stall=1 -> instr_valid=0 next cycle, next entry instr_pc=8'h0A.
REQ-037 pc=8'hFF issue -> without macro next instr_pc=8'h00; with IFETCH_WRAP_HALT_EN halted=1 after entry 8'hFF.
REQ-038 rst=1 mid-stream with instr_valid=1 -> all outputs zero, state IDLE next cycle; start then refetches from RESET_PC.
